sc_datamem_io: RTL and testbench

Parametrised data-memory and memory-mapped I/O block for the single-cycle/pipelined CPU data port. It decodes each access into either a word-addressed synchronous RAM with byte enables or an I/O register file. The I/O register file holds N_OUT output registers, N_IN synchronised input ports with sticky change flags, an interrupt mask and a free-running cycle counter. It replaces the fixed 32-word/2-input/3-output data-memory wrapper in the CPU top level.

---
 rtl/sc_io_pkg.sv | 16 +
 rtl/io_in_sync.sv | 39 +++
 rtl/sc_datamem_io.sv | 107 ++++++++++
 tb/tb_sc_datamem_io.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_io_pkg.sv
// Shared constants for the data-memory / memory-mapped I/O block: I/O word
// offsets and the RAM/I/O select bit position.
package sc_io_pkg;

  localparam int OFS_OUT  = 0;
  localparam int OFS_IN   = 16;
  localparam int OFS_CNT  = 28;
  localparam int OFS_MASK = 29;
  localparam int OFS_FLAG = 30;

  // Address bit that selects I/O over RAM for a RAM of mem_words 32-bit words.
  function automatic int io_bit(input int mem_words);
    return $clog2(mem_words) + 2;
  endfunction

endpackage

// File: rtl/io_in_sync.sv
// One input channel: two-flop synchroniser, history register and a sticky
// change flag that is cleared by clr_i unless a new change arrives that edge.
module io_in_sync #(
  parameter int IN_W = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IN_W-1:0] pin_i,
  input  logic            clr_i,
  output logic [IN_W-1:0] sync_o,
  output logic            flag_o
);

  logic [IN_W-1:0] s1_q, s2_q, s3_q;
  logic            flag_q, flag_d;

  // Set has priority over clear so a change is never lost to a racing W1C.
  assign flag_d = (s2_q != s3_q) | (flag_q & ~clr_i);

  // NOTE: non-blocking assignments let the shift chain s1->s2->s3 update as
  // one edge; blocking would collapse it into a single stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      flag_q <= 1'b0;
    end else begin
      s1_q   <= pin_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      flag_q <= flag_d;
    end
  end

  assign sync_o = s2_q;
  assign flag_o = flag_q;

endmodule

// File: rtl/sc_datamem_io.sv
// CPU data port: word-addressed byte-enabled RAM plus an I/O register file with
// output registers, synchronised inputs with change flags, irq mask and counter.
module sc_datamem_io
  import sc_io_pkg::*;
#(
  parameter int MEM_WORDS = 32,
  parameter int N_IN      = 3,
  parameter int IN_W      = 4,
  parameter int N_OUT     = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            addr,
  input  logic [31:0]            datain,
  input  logic                   we,
  input  logic [3:0]             be,
  output logic [31:0]            dataout,
  input  logic [N_IN*IN_W-1:0]   in_port,
  output logic [N_OUT*32-1:0]    out_port,
  output logic                   irq
);

  localparam int IO_BIT = io_bit(MEM_WORDS);
  localparam int AW     = IO_BIT - 2;

  logic          io_sel;
  logic [AW-1:0] word_idx;
  logic [4:0]    ofs;
  logic          io_wr, ram_wr;
  logic          unused_addr;

  assign io_sel      = addr[IO_BIT];
  assign word_idx    = addr[IO_BIT-1:2];
  assign ofs         = addr[6:2];
  assign io_wr       = we & io_sel & (be == 4'hF);
  assign ram_wr      = we & ~io_sel & ~reset;
  assign unused_addr = ^{addr[31:IO_BIT+1], addr[1:0]};

  logic [31:0]     mem [MEM_WORDS];
  logic [31:0]     out_q [N_OUT];
  logic [N_IN-1:0] mask_q;
  logic [31:0]     cnt_q;
  logic [31:0]     dout_q;
  logic            irq_q;
  logic [31:0]     io_rdata;

  logic [IN_W-1:0] sync_in [N_IN];
  logic [N_IN-1:0] chg_flag, flag_clr;

  assign flag_clr = {N_IN{io_wr && (ofs == 5'(OFS_FLAG))}} & datain[N_IN-1:0];

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    io_in_sync #(.IN_W(IN_W)) u_sync (
      .clock  (clock),
      .reset  (reset),
      .pin_i  (in_port[i*IN_W +: IN_W]),
      .clr_i  (flag_clr[i]),
      .sync_o (sync_in[i]),
      .flag_o (chg_flag[i])
    );
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    assign out_port[j*32 +: 32] = out_q[j];
  end

  // NOTE: every path assigns io_rdata after its default, so no latch forms.
  always_comb begin
    io_rdata = '0;
    for (int j = 0; j < N_OUT; j++)
      if (ofs == 5'(OFS_OUT + j)) io_rdata = out_q[j];
    for (int i = 0; i < N_IN; i++)
      if (ofs == 5'(OFS_IN + i)) io_rdata = 32'(sync_in[i]);
    // The counter reads as the value it takes on the read edge.
    if (ofs == 5'(OFS_CNT))  io_rdata = cnt_q + 32'd1;
    if (ofs == 5'(OFS_MASK)) io_rdata = 32'(mask_q);
    if (ofs == 5'(OFS_FLAG)) io_rdata = 32'(chg_flag);
  end

  // NOTE: the RAM array has no reset so it maps onto block/distributed RAM.
  always_ff @(posedge clock) begin
    if (ram_wr)
      for (int k = 0; k < 4; k++)
        if (be[k]) mem[word_idx][8*k +: 8] <= datain[8*k +: 8];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < N_OUT; j++) out_q[j] <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      for (int j = 0; j < N_OUT; j++)
        if (io_wr && (ofs == 5'(OFS_OUT + j))) out_q[j] <= datain;
      if (io_wr && (ofs == 5'(OFS_MASK))) mask_q <= datain[N_IN-1:0];
      cnt_q  <= (io_wr && (ofs == 5'(OFS_CNT))) ? datain : cnt_q + 32'd1;
      dout_q <= io_sel ? io_rdata : mem[word_idx];
      irq_q  <= |(chg_flag & mask_q);
    end
  end

  assign dataout = dout_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_sc_datamem_io.sv
// Self-checking bench for sc_datamem_io: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the memory map.
module tb_sc_datamem_io;

  localparam int MEM_WORDS = 32;
  localparam int N_IN      = 3;
  localparam int IN_W      = 4;
  localparam int N_OUT     = 3;
  localparam int IO_BIT    = $clog2(MEM_WORDS) + 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [31:0]          addr, datain, dataout;
  logic                 we, irq;
  logic [3:0]           be;
  logic [N_IN*IN_W-1:0] in_port;
  logic [N_OUT*32-1:0]  out_port;
  logic [IN_W-1:0]      pins [N_IN];

  always #5 clock = ~clock;

  always_comb
    for (int i = 0; i < N_IN; i++) in_port[i*IN_W +: IN_W] = pins[i];

  sc_datamem_io #(
    .MEM_WORDS(MEM_WORDS), .N_IN(N_IN), .IN_W(IN_W), .N_OUT(N_OUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .addr     (addr),
    .datain   (datain),
    .we       (we),
    .be       (be),
    .dataout  (dataout),
    .in_port  (in_port),
    .out_port (out_port),
    .irq      (irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Behavioural model state
  logic [31:0]     m_mem [MEM_WORDS];
  bit              m_mok [MEM_WORDS];
  logic [31:0]     m_out [N_OUT];
  logic [N_IN-1:0] m_mask, m_flag;
  logic [31:0]     m_cnt, m_dout;
  bit              m_dout_ok, m_irq;
  logic [IN_W-1:0] m_hist [3][N_IN];  // [0] newest pin sample, [1] visible value, [2] previous visible

  function automatic logic [31:0] m_io_read(input int o);
    if (o < N_OUT) return m_out[o];
    if (o >= 16 && o < 16 + N_IN) return 32'(m_hist[1][o-16]);
    if (o == 28) return m_cnt + 32'd1;
    if (o == 29) return 32'(m_mask);
    if (o == 30) return 32'(m_flag);
    return 32'd0;
  endfunction

  task automatic tick(input bit rst, input logic [31:0] a, input logic [31:0] d,
                      input bit w, input logic [3:0] b);
    bit              io, io_w;
    int              o, widx;
    logic [N_IN-1:0] setv, clrv;
    reset = rst; addr = a; datain = d; we = w; be = b;
    @(posedge clock);
    io   = a[IO_BIT];
    o    = int'(a[6:2]);
    widx = int'(a[IO_BIT-1:2]);
    io_w = io && w && (b == 4'hF);
    if (rst) begin
      for (int j = 0; j < N_OUT; j++) m_out[j] = '0;
      m_mask = '0; m_flag = '0; m_cnt = '0; m_dout = '0; m_dout_ok = 1; m_irq = 0;
      for (int h = 0; h < 3; h++)
        for (int i = 0; i < N_IN; i++) m_hist[h][i] = '0;
    end else begin
      if (io) begin
        m_dout = m_io_read(o); m_dout_ok = 1;
      end else begin
        m_dout = m_mem[widx]; m_dout_ok = m_mok[widx];
      end
      m_irq = |(m_flag & m_mask);
      setv = '0;
      for (int i = 0; i < N_IN; i++) setv[i] = (m_hist[1][i] != m_hist[2][i]);
      clrv = (io_w && o == 30) ? d[N_IN-1:0] : '0;
      m_flag = (m_flag & ~clrv) | setv;
      if (io_w && o < N_OUT) m_out[o] = d;
      if (io_w && o == 29) m_mask = d[N_IN-1:0];
      m_cnt = (io_w && o == 28) ? d : m_cnt + 32'd1;
      if (!io && w) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) m_mem[widx][8*k +: 8] = d[8*k +: 8];
        if (b == 4'hF) m_mok[widx] = 1;
      end
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      for (int i = 0; i < N_IN; i++) m_hist[0][i] = pins[i];
    end
    #1;
    if (m_dout_ok) check("dataout", dataout, m_dout);
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    for (int j = 0; j < N_OUT; j++)
      check($sformatf("out_port%0d", j), out_port[j*32 +: 32], m_out[j]);
  endtask

  function automatic logic [31:0] io_addr(input int o);
    return 32'h80 | (32'(o) << 2);
  endfunction

  initial begin
    logic [31:0] a;
    for (int i = 0; i < N_IN; i++) pins[i] = '0;
    for (int w = 0; w < MEM_WORDS; w++) m_mok[w] = 0;

    // Reset state; counter read right after reset shows 1
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("reset_dataout", dataout, 32'd0);
    tick(0, io_addr(28), 0, 0, 0);
    check("cnt_after_reset", dataout, 32'd1);
    tick(0, io_addr(0), 0, 0, 0);
    check("reset_out0", dataout, 32'd0);
    tick(0, io_addr(29), 0, 0, 0);
    check("reset_mask", dataout, 32'd0);
    tick(0, io_addr(30), 0, 0, 0);
    check("reset_flag", dataout, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);

    for (int w = 0; w < MEM_WORDS; w++)
      tick(0, 32'(w) << 2, 32'hA5A5A5A5 ^ (32'(w) * 32'h01010101), 1, 4'hF);

    // RAM byte-masked merge and RAM/I-O separation
    tick(0, 32'h14, 32'hDEADBEEF, 1, 4'hF);
    tick(0, 32'h14, 32'h0000AA00, 1, 4'b0010);
    tick(0, 32'h14, 0, 0, 0);
    check("ram_merge", dataout, 32'hDEADAAEF);
    tick(0, io_addr(5), 0, 0, 0);
    check("io_alias_word5", dataout, 32'd0);

    // Output register write, partial-enable I/O write ignored, hole reads 0
    tick(0, io_addr(1), 32'h12345678, 1, 4'hF);
    check("out1_write", out_port[63:32], 32'h12345678);
    tick(0, io_addr(1), 32'h00000000, 1, 4'h3);
    check("out1_partial_ignored", out_port[63:32], 32'h12345678);
    tick(0, io_addr(27), 0, 0, 0);
    check("hole_27", dataout, 32'd0);

    // Counter load and wrap
    tick(0, io_addr(28), 32'hFFFFFFFE, 1, 4'hF);
    tick(0, io_addr(28), 0, 0, 0);
    check("cnt_ffffffff", dataout, 32'hFFFFFFFF);
    tick(0, io_addr(28), 0, 0, 0);
    check("cnt_wrap", dataout, 32'h00000000);

    // Reset beats a simultaneous write
    tick(1, io_addr(0), 32'hCAFEF00D, 1, 4'hF);
    check("reset_vs_write", out_port[31:0], 32'd0);

    // Input change on ch2 -> sync value, flag, irq, W1C
    tick(0, io_addr(29), 32'h4, 1, 4'hF);
    tick(0, io_addr(29), 0, 0, 0);
    pins[2] = 4'h9;
    tick(0, io_addr(18), 0, 0, 0);
    tick(0, io_addr(18), 0, 0, 0);
    tick(0, io_addr(18), 0, 0, 0);
    check("sync_in2", dataout, 32'h9);
    tick(0, io_addr(30), 0, 0, 0);
    check("flag_ch2", dataout, 32'h4);
    check("irq_high", {31'd0, irq}, 32'd1);
    tick(0, io_addr(30), 32'h4, 1, 4'hF);
    tick(0, io_addr(30), 0, 0, 0);
    check("flag_cleared", dataout, 32'd0);
    check("irq_low", {31'd0, irq}, 32'd0);

    // Flag set races a W1C on the same edge: set wins
    pins[0] = 4'h1;
    tick(0, io_addr(30), 0, 0, 0);
    tick(0, io_addr(30), 0, 0, 0);
    tick(0, io_addr(30), 32'h1, 1, 4'hF);
    tick(0, io_addr(30), 0, 0, 0);
    check("set_beats_clear", dataout, 32'h1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      a = $urandom();
      r = $urandom_range(0, 9);
      if (r < 4) begin
        a[IO_BIT] = 1'b0;
      end else begin
        int o;
        case ($urandom_range(0, 6))
          0:       o = $urandom_range(0, N_OUT - 1);
          1:       o = 16 + $urandom_range(0, N_IN - 1);
          2:       o = 28;
          3:       o = 29;
          4:       o = 30;
          default: o = $urandom_range(0, 31);
        endcase
        a[IO_BIT] = 1'b1;
        a[6:2]    = 5'(o);
      end
      if ($urandom_range(0, 7) == 0) pins[$urandom_range(0, N_IN - 1)] = IN_W'($urandom());
      tick($urandom_range(0, 499) == 0, a, $urandom(), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
